// File: rtl/ct_had_pkg.sv
// Shared HAD common-domain types: halt sequencer state encoding and core-count limit.
package ct_had_pkg;

    localparam int unsigned HAD_MAX_CORE = 4;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StHaltWait   = 2'd1,
        StHalted     = 2'd2,
        StResumeWait = 2'd3
    } had_halt_st_e;

    function automatic logic is_wait_st(input had_halt_st_e st);
        return (st == StHaltWait) || (st == StResumeWait);
    endfunction

endpackage

// File: rtl/ct_had_tmo_cnt.sv
// Wait-phase timeout counter: synchronous clear, count enable, saturates at all-ones.
module ct_had_tmo_cnt #(
    parameter int unsigned TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [TMO_W-1:0] cnt_q;

    assign done = &cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ct_had_halt_ctrl.sv
// Multi-core halt/resume sequencer: host halt/resume commands, self-halt cross-trigger,
// per-core ack waits under a shared timeout.
module ct_had_halt_ctrl
    import ct_had_pkg::*;
#(
    parameter int unsigned NUM_CORE = 2,
    parameter int unsigned TMO_W    = 8
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    input  logic                host_halt_req,
    input  logic                host_resume_req,
    input  logic [NUM_CORE-1:0] host_core_mask,
    input  logic [NUM_CORE-1:0] cti_en,
    input  logic [NUM_CORE-1:0] core_dbg_mask,
    input  logic [NUM_CORE-1:0] core_enter_dbg,
    input  logic [NUM_CORE-1:0] core_dbg_ack,
    input  logic                err_clr,
    output logic [NUM_CORE-1:0] core_halt_req,
    output logic [NUM_CORE-1:0] core_resume_req,
    output logic [NUM_CORE-1:0] halted_mask,
    output logic                busy,
    output logic                tmo_err
);

    had_halt_st_e        state_q, state_d;
    logic [NUM_CORE-1:0] tgt_q, tgt_d;
    logic [NUM_CORE-1:0] evt_set, host_set, merged;
    logic [NUM_CORE-1:0] halt_req_d, resume_req_d;
    logic                cti_hit, tmo_done, tmo_fire, tmo_clr;

    always_comb begin
        cti_hit      = |(core_enter_dbg & cti_en);
        evt_set      = core_enter_dbg | (cti_hit ? cti_en : '0);
        host_set     = host_halt_req ? host_core_mask : '0;
        merged       = (tgt_q | host_set | evt_set) & ~core_dbg_mask;
        state_d      = state_q;
        tgt_d        = tgt_q & ~core_dbg_mask;
        halt_req_d   = '0;
        resume_req_d = '0;
        tmo_fire     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A self-halt without cti_en does not start a sequence from idle.
                tgt_d = (host_set | (cti_hit ? evt_set : '0)) & ~core_dbg_mask;
                if (cti_hit || tgt_d != '0) state_d = StHaltWait;
            end
            StHaltWait: begin
                tgt_d = merged;
                if ((core_dbg_ack & merged) == merged) begin
                    state_d = StHalted;
                end else if (tmo_done) begin
                    tmo_fire = 1'b1;
                    tgt_d    = merged & core_dbg_ack;
                    state_d  = StHalted;
                end else begin
                    halt_req_d = merged & ~core_dbg_ack;
                end
            end
            StHalted: begin
                tgt_d = merged;
                // Only cores newly added and not yet in debug need another wait phase.
                if ((merged & ~tgt_q & ~core_dbg_ack) != '0) begin
                    state_d = StHaltWait;
                end else if (host_resume_req) begin
                    resume_req_d = merged;
                    state_d      = (merged == '0) ? StIdle : StResumeWait;
                end
            end
            StResumeWait: begin
                if ((core_dbg_ack & tgt_d) == '0) begin
                    tgt_d   = '0;
                    state_d = StIdle;
                end else if (tmo_done) begin
                    tmo_fire = 1'b1;
                    tgt_d    = '0;
                    state_d  = StIdle;
                end
            end
        endcase
    end

    assign tmo_clr = is_wait_st(state_d) && (state_d != state_q);

    ct_had_tmo_cnt #(
        .TMO_W (TMO_W)
    ) u_tmo_cnt (
        .clk  (forever_cpuclk),
        .rst  (cpurst),
        .clr  (tmo_clr),
        .en   (is_wait_st(state_q)),
        .done (tmo_done)
    );

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q         <= StIdle;
            tgt_q           <= '0;
            core_halt_req   <= '0;
            core_resume_req <= '0;
            halted_mask     <= '0;
            busy            <= 1'b0;
            tmo_err         <= 1'b0;
        end else begin
            state_q         <= state_d;
            tgt_q           <= tgt_d;
            core_halt_req   <= halt_req_d;
            core_resume_req <= resume_req_d;
            halted_mask     <= core_dbg_ack & ~core_dbg_mask;
            busy            <= is_wait_st(state_d);
            if (tmo_fire) begin
                tmo_err <= 1'b1;
            end else if (err_clr) begin
                tmo_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ct_had_halt_ctrl.sv
// Self-checking bench for ct_had_halt_ctrl: directed vector table, timeout/reset sequences,
// then random stimulus against a behavioural model.
module tb_ct_had_halt_ctrl;

    localparam int NC        = 2;
    localparam int TMO       = 4;
    localparam int TMO_LIMIT = (1 << TMO) - 1;

    localparam int PH_IDLE     = 0;
    localparam int PH_HALTING  = 1;
    localparam int PH_HALTED   = 2;
    localparam int PH_RESUMING = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_halt_req = 1'b0, host_resume_req = 1'b0, err_clr = 1'b0;
    logic [NC-1:0] host_core_mask = '0, cti_en = '0, core_dbg_mask = '0;
    logic [NC-1:0] core_enter_dbg = '0, core_dbg_ack = '0;
    logic [NC-1:0] core_halt_req, core_resume_req, halted_mask;
    logic          busy, tmo_err;

    ct_had_halt_ctrl #(
        .NUM_CORE (NC),
        .TMO_W    (TMO)
    ) dut (
        .forever_cpuclk  (clk),
        .cpurst          (rst),
        .host_halt_req   (host_halt_req),
        .host_resume_req (host_resume_req),
        .host_core_mask  (host_core_mask),
        .cti_en          (cti_en),
        .core_dbg_mask   (core_dbg_mask),
        .core_enter_dbg  (core_enter_dbg),
        .core_dbg_ack    (core_dbg_ack),
        .err_clr         (err_clr),
        .core_halt_req   (core_halt_req),
        .core_resume_req (core_resume_req),
        .halted_mask     (halted_mask),
        .busy            (busy),
        .tmo_err         (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       halt;
        logic       resume;
        logic [1:0] hmask;
        logic [1:0] cti;
        logic [1:0] dmask;
        logic [1:0] enter;
        logic [1:0] ack;
        logic       clr;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [1:0] x_halt;
        logic [1:0] x_res;
        logic [1:0] x_hm;
        logic       x_busy;
        logic       x_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic stim_t st(input logic h, input logic r, input logic [1:0] hm, cti, dm,
                                 en, ack, input logic c);
        stim_t s;
        s = '{halt: h, resume: r, hmask: hm, cti: cti, dmask: dm, enter: en, ack: ack, clr: c};
        return s;
    endfunction

    function automatic vec_t vx(input stim_t s, input logic [1:0] xh, xr, xm,
                                input logic xb, xe);
        vec_t v;
        v = '{s: s, x_halt: xh, x_res: xr, x_hm: xm, x_busy: xb, x_err: xe};
        return v;
    endfunction

    task automatic drive(input stim_t s);
        host_halt_req   = s.halt;
        host_resume_req = s.resume;
        host_core_mask  = s.hmask;
        cti_en          = s.cti;
        core_dbg_mask   = s.dmask;
        core_enter_dbg  = s.enter;
        core_dbg_ack    = s.ack;
        err_clr         = s.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] xh, xr, xm,
                              input logic xb, xe);
        chk({tag, ".halt_req"}, core_halt_req, xh);
        chk({tag, ".resume_req"}, core_resume_req, xr);
        chk({tag, ".halted_mask"}, halted_mask, xm);
        chk({tag, ".busy"}, {1'b0, busy}, {1'b0, xb});
        chk({tag, ".tmo_err"}, {1'b0, tmo_err}, {1'b0, xe});
    endtask

    // Behavioural reference: phase, target set and cycles spent in the current wait.
    int         ph;
    int         age;
    logic [1:0] m_tgt;
    logic       m_err;
    logic [1:0] e_halt, e_res, e_hm;
    logic       e_busy;

    function automatic logic covers(input logic [1:0] set, input logic [1:0] acked);
        for (int i = 0; i < NC; i++) if (set[i] && !acked[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_cycle(input stim_t s);
        logic [1:0] live, ev, hs, nt;
        logic       trig, fire, newpend;
        int         nph;
        live    = ~s.dmask;
        trig    = |(s.enter & s.cti);
        ev      = s.enter | (trig ? s.cti : 2'b00);
        hs      = s.halt ? s.hmask : 2'b00;
        nph     = ph;
        fire    = 1'b0;
        newpend = 1'b0;
        e_halt  = 2'b00;
        e_res   = 2'b00;
        nt      = m_tgt & live;
        case (ph)
            PH_IDLE: begin
                nt = (hs | (trig ? ev : 2'b00)) & live;
                if (trig || nt != 2'b00) nph = PH_HALTING;
            end
            PH_HALTING: begin
                nt = (m_tgt | hs | ev) & live;
                if (covers(nt, s.ack)) nph = PH_HALTED;
                else if (age == TMO_LIMIT) begin
                    fire = 1'b1;
                    nt   = nt & s.ack;
                    nph  = PH_HALTED;
                end else e_halt = nt & ~s.ack;
            end
            PH_HALTED: begin
                nt = (m_tgt | hs | ev) & live;
                for (int i = 0; i < NC; i++) if (nt[i] && !m_tgt[i] && !s.ack[i]) newpend = 1'b1;
                if (newpend) nph = PH_HALTING;
                else if (s.resume) begin
                    if (nt == 2'b00) nph = PH_IDLE;
                    else begin
                        e_res = nt;
                        nph   = PH_RESUMING;
                    end
                end
            end
            default: begin
                if ((s.ack & nt) == 2'b00) begin
                    nt  = 2'b00;
                    nph = PH_IDLE;
                end else if (age == TMO_LIMIT) begin
                    fire = 1'b1;
                    nt   = 2'b00;
                    nph  = PH_IDLE;
                end
            end
        endcase
        if (nph != ph) age = 0;
        else if (age < TMO_LIMIT) age = age + 1;
        if (fire) m_err = 1'b1;
        else if (s.clr) m_err = 1'b0;
        e_hm   = s.ack & live;
        e_busy = (nph == PH_HALTING) || (nph == PH_RESUMING);
        ph     = nph;
        m_tgt  = nt;
    endtask

    vec_t  tbl[27];
    stim_t cur;
    stim_t rs;

    initial begin
        // Hand-derived cycle vectors: halt/resume, cross-trigger, debug mask, idle no-ops.
        tbl[0]  = vx(st(1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 1, 0);
        tbl[1]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b11, 2'b00, 2'b00, 1, 0);
        tbl[2]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b11, 2'b00, 2'b00, 1, 0);
        tbl[3]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 0, 0);
        tbl[4]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 0, 0);
        tbl[5]  = vx(st(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b11, 2'b11, 1, 0);
        tbl[6]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 1, 0);
        tbl[7]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 1, 0);
        tbl[8]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 1, 0);
        tbl[9]  = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 1, 0);
        tbl[10] = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[11] = vx(st(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[12] = vx(st(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 1, 0);
        tbl[13] = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b01, 2'b00, 2'b00, 1, 0);
        tbl[14] = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0), 2'b00, 2'b00, 2'b01, 0, 0);
        tbl[15] = vx(st(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0), 2'b00, 2'b01, 2'b01, 1, 0);
        tbl[16] = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[17] = vx(st(0, 0, 2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 0), 2'b00, 2'b00, 2'b01, 1, 0);
        tbl[18] = vx(st(0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 0), 2'b10, 2'b00, 2'b01, 1, 0);
        tbl[19] = vx(st(0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b11, 0, 0);
        tbl[20] = vx(st(0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0), 2'b00, 2'b11, 2'b11, 1, 0);
        tbl[21] = vx(st(0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[22] = vx(st(1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[23] = vx(st(0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[24] = vx(st(0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 0), 2'b00, 2'b00, 2'b01, 0, 0);
        tbl[25] = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[26] = vx(st(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0), 2'b00, 2'b00, 2'b00, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_outs("in_reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_outs("after_reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].s);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].x_halt, tbl[i].x_res, tbl[i].x_hm,
                       tbl[i].x_busy, tbl[i].x_err);
        end

        // Halt timeout: core1 never acks; expires 16 edges after the halt is accepted.
        cur = st(1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 0);
        drive(cur);
        tick();
        check_outs("tmo_enter", 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        cur.halt = 1'b0;
        drive(cur);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 1 || i == 15) check_outs($sformatf("tmo_wait%0d", i), 2'b10, 2'b00, 2'b01,
                                              1'b1, 1'b0);
        end
        tick();
        check_outs("tmo_fire", 2'b00, 2'b00, 2'b01, 1'b0, 1'b1);
        cur.clr = 1'b1;
        drive(cur);
        tick();
        check_outs("tmo_clr", 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        cur = st(1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 0);
        drive(cur);
        tick();
        check_outs("tmo2_enter", 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        cur.halt = 1'b0;
        drive(cur);
        repeat (15) tick();
        check_outs("tmo2_wait", 2'b10, 2'b00, 2'b01, 1'b1, 1'b0);
        cur.clr = 1'b1;
        drive(cur);
        tick();
        check_outs("tmo2_fire_vs_clr", 2'b00, 2'b00, 2'b01, 1'b0, 1'b1);
        cur = st(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0);
        drive(cur);
        tick();
        check_outs("tmo_resume", 2'b00, 2'b01, 2'b01, 1'b1, 1'b1);
        cur = st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        drive(cur);
        tick();
        check_outs("tmo_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a halt wait.
        cur = st(1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 0);
        drive(cur);
        tick();
        cur.halt = 1'b0;
        drive(cur);
        tick();
        check_outs("pre_rst", 2'b10, 2'b00, 2'b01, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        cur = st(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        drive(cur);
        rst = 1'b0;
        tick();
        check_outs("post_rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Random stimulus against the model, starting from idle.
        ph    = PH_IDLE;
        age   = 0;
        m_tgt = 2'b00;
        m_err = 1'b0;
        rs    = '0;
        rs.cti = 2'b11;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) rs.ack[0] = ~rs.ack[0];
            if ($urandom_range(0, 5) == 0) rs.ack[1] = ~rs.ack[1];
            if ($urandom_range(0, 39) == 0)
                rs.dmask = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 99) == 0) rs.cti = 2'($urandom_range(0, 3));
            rs.halt   = ($urandom_range(0, 7) == 0);
            rs.resume = ($urandom_range(0, 6) == 0);
            rs.hmask  = 2'($urandom_range(0, 3));
            rs.enter  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rs.clr    = ($urandom_range(0, 19) == 0);
            model_cycle(rs);
            drive(rs);
            tick();
            check_outs($sformatf("rnd%0d", n), e_halt, e_res, e_hm, e_busy, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
